pll_reset_sequencer: RTL and testbench
======================================

Name: pll_reset_sequencer

Overview:
- Parametrised clock-domain bring-up controller that sits beside the PLL wrapper and runs on the free-running reference clock.
- Drives the PLL reset and monitors the PLL locked flag. Once lock has been stable, it releases per-domain resets one after another, with a fixed spacing between them.
- Handles lock-acquisition timeout, lock loss mid-run and software-requested restarts. Replaces ad-hoc "reset = ~locked" wiring for N output clocks.

Parameters:
- N_DOMAINS, 3: number of downstream clock domains (outputs of the PLL); range 1..16.
- PLL_RST_CYCLES, 16: cycles pll_rst is held high per reset attempt; at least 1.
- LOCK_TIMEOUT, 4096: cycles allowed in WAIT_LOCK before a retry; at least 1.
- LOCK_STABLE, 256: consecutive synchronised-locked cycles required before releasing any domain; at least 1.
- STAGGER, 8: cycles between successive domain reset releases; at least 1.
- CNT_WIDTH, 8: width of the lock-loss and retry event counters.

Ports:
- clk, input, 1: reference clock, free-running, never gated.
- reset_n, input, 1: asynchronous active-low reset. Assertion is asynchronous; deassertion is synchronised externally.
- pll_locked, input, 1: PLL locked flag, asynchronous to clk.
- restart, input, 1: single-cycle request for a full re-sequence.
- pll_rst, output, 1: active-high PLL reset.
- domain_reset, output, N_DOMAINS: active-high per-domain resets; bit i belongs to PLL outclk_i.
- ready, output, 1: all domains released and lock held.
- lock_loss_cnt, output, CNT_WIDTH: saturating count of lock losses after RELEASE has been entered.
- retry_cnt, output, CNT_WIDTH: saturating count of WAIT_LOCK timeouts.

Behaviour:
- Reset (reset_n=0), applied immediately: state=PLL_RST, pll_rst=1, domain_reset=all 1, ready=0, both counters=0, internal counters=0.
- Lock synchroniser: pll_locked passes through a 2-flop synchroniser giving lk. There is 2 cycles of latency and no other filtering.
- Registered outputs: all outputs are registered and decoded from the current state and the release index.
- PLL_RST state:
  - pll_rst=1, domain_reset=all 1. Count PLL_RST_CYCLES cycles, then go to WAIT_LOCK.
  - pll_rst is therefore high for exactly PLL_RST_CYCLES cycles after entry.
- WAIT_LOCK state:
  - pll_rst=0. A timer counts cycles.
  - lk=1: go to STABLE, stable counter=1.
  - Timer reaches LOCK_TIMEOUT with lk still 0: retry_cnt+1 (saturating), go to PLL_RST.
- STABLE state:
  - lk=1 increments the stable counter. When it reaches LOCK_STABLE, go to RELEASE with idx=0.
  - lk=0: go back to WAIT_LOCK, timer=0. This is not counted as a lock loss.
- RELEASE state:
  - On entry, domain_reset[0] is cleared. Every STAGGER cycles idx increments and domain_reset[idx] is cleared.
  - Release order is fixed, low index first. A released bit stays 0 until the next abort.
  - STAGGER cycles after the last bit is cleared, go to RUN.
- RUN state: ready=1. Stay here indefinitely.
- Lock loss (lk=0 in RELEASE or RUN):
  - Next cycle: domain_reset=all 1, ready=0, lock_loss_cnt+1 (saturating at all-ones), state=PLL_RST.
  - No partial hold; every domain is reset together.
- restart=1 in any state other than PLL_RST: same action as lock loss, except lock_loss_cnt is not incremented. restart is ignored in PLL_RST.
- Simultaneous restart and lock loss: treated as lock loss, so the counter increments once.
- Counter widths: internal counters are sized $clog2(max(PLL_RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE, STAGGER)+1). None of them wraps; each is cleared on state entry.
- N_DOMAINS=1: domain_reset[0] clears on RELEASE entry, and RUN follows STAGGER cycles later.
- Invariants:
  - domain_reset bits are monotonic within one sequence: a bit is never cleared while a lower-indexed bit is set.
  - ready=1 implies domain_reset=0.
  - pll_rst=1 implies domain_reset=all 1.

Decomposition:
- Shared package pll_seq_pkg holds:
  - the state enum (PLL_RST, WAIT_LOCK, STABLE, RELEASE, RUN);
  - a width-calc function for the internal counters;
  - the default timing constants.
- One sub-module, sync_2ff (2-flop synchroniser with async active-low reset to 0), is used for pll_locked. It is reusable elsewhere in the codebase.

Test Plan:
Benches use PLL_RST_CYCLES=4, LOCK_TIMEOUT=32, LOCK_STABLE=8, STAGGER=2, N_DOMAINS=3, CNT_WIDTH=4 unless stated.
1. Nominal bring-up: release reset_n, raise pll_locked at cycle 10 -> pll_rst high for cycles 0-3; domain_reset 111→110→100→000 at 2-cycle spacing after 8 stable lk cycles; ready=1 two cycles after 000.
2. Timeout retry: hold pll_locked=0 -> pll_rst re-pulses for 4 cycles every 36 cycles; retry_cnt increments 1,2,3…, saturates at 15; ready stays 0.
3. Glitch during STABLE: locked high for 5 cycles, low for 1, then high -> no domain release until 8 fresh consecutive lk cycles; lock_loss_cnt stays 0.
4. Lock loss mid-RELEASE: drop pll_locked when domain_reset=100 -> 2 cycles later plus 1, domain_reset=111, pll_rst=1, lock_loss_cnt=1; the full sequence repeats.
5. restart in RUN: pulse restart for 1 cycle -> next cycle domain_reset=111, ready=0, pll_rst=1; lock_loss_cnt unchanged; re-reaches RUN.
6. Async reset mid-RUN: assert reset_n between clock edges -> outputs go to reset values immediately, without waiting for an edge; both counters return to 0.

Source files
------------

// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL reset sequencer: state encoding, default timing
// and the sizing rule for the internal cycle counters.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4
    } state_t;

    localparam int DEF_N_DOMAINS      = 3;
    localparam int DEF_PLL_RST_CYCLES = 16;
    localparam int DEF_LOCK_TIMEOUT   = 4096;
    localparam int DEF_LOCK_STABLE    = 256;
    localparam int DEF_STAGGER        = 8;
    localparam int DEF_CNT_WIDTH      = 8;

    // One shared counter serves every timed state, so it must hold the largest limit.
    function automatic int cnt_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for bringing asynchronous level signals into the clk domain.
// Both stages reset to 0, so a synchronised flag reads inactive until proven otherwise.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Brings up a PLL and its output clock domains: pulses the PLL reset, waits for a
// stable lock, then releases the domain resets one by one with a fixed spacing.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int N_DOMAINS      = DEF_N_DOMAINS,
    parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
    parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
    parameter int LOCK_STABLE    = DEF_LOCK_STABLE,
    parameter int STAGGER        = DEF_STAGGER,
    parameter int CNT_WIDTH      = DEF_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 pll_locked,
    input  logic                 restart,
    output logic                 pll_rst,
    output logic [N_DOMAINS-1:0] domain_reset,
    output logic                 ready,
    output logic [CNT_WIDTH-1:0] lock_loss_cnt,
    output logic [CNT_WIDTH-1:0] retry_cnt
);

    localparam int CW = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE, STAGGER);
    localparam int IW = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;

    logic          lk;
    state_t        state;
    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;
    logic          lock_lost;
    logic          abort;

    sync_2ff #(.WIDTH(1)) u_lock_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (pll_locked),
        .q       (lk)
    );

    // Lock loss only matters once domains are being released; earlier drops just re-wait.
    assign lock_lost = !lk && (state == RELEASE || state == RUN);
    assign abort     = lock_lost || (restart && state != PLL_RST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= PLL_RST;
            cnt           <= '0;
            idx           <= '0;
            pll_rst       <= 1'b1;
            domain_reset  <= '1;
            ready         <= 1'b0;
            lock_loss_cnt <= '0;
            retry_cnt     <= '0;
        end else if (abort) begin
            state        <= PLL_RST;
            cnt          <= '0;
            idx          <= '0;
            pll_rst      <= 1'b1;
            domain_reset <= '1;
            ready        <= 1'b0;
            if (lock_lost && lock_loss_cnt != '1)
                lock_loss_cnt <= lock_loss_cnt + CNT_WIDTH'(1);
        end else begin
            case (state)
                PLL_RST: begin
                    if (cnt == CW'(PLL_RST_CYCLES - 1)) begin
                        state   <= WAIT_LOCK;
                        cnt     <= '0;
                        pll_rst <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                WAIT_LOCK: begin
                    if (lk) begin
                        state <= STABLE;
                        cnt   <= CW'(1);
                    end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
                        state   <= PLL_RST;
                        cnt     <= '0;
                        pll_rst <= 1'b1;
                        if (retry_cnt != '1)
                            retry_cnt <= retry_cnt + CNT_WIDTH'(1);
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                STABLE: begin
                    if (!lk) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt >= CW'(LOCK_STABLE - 1)) begin
                        state        <= RELEASE;
                        cnt          <= '0;
                        idx          <= '0;
                        domain_reset <= {N_DOMAINS{1'b1}} << 1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RELEASE: begin
                    // Shifting a zero in from the bottom keeps releases strictly low-index first.
                    if (cnt == CW'(STAGGER - 1)) begin
                        cnt <= '0;
                        if (idx == IW'(N_DOMAINS - 1)) begin
                            state <= RUN;
                            ready <= 1'b1;
                        end else begin
                            idx          <= idx + IW'(1);
                            domain_reset <= domain_reset << 1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RUN: begin
                    ready <= 1'b1;
                end
                default: begin
                    state        <= PLL_RST;
                    cnt          <= '0;
                    idx          <= '0;
                    pll_rst      <= 1'b1;
                    domain_reset <= '1;
                    ready        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with short timing so every phase is reachable.
// Cycle numbers count rising edges after reset_n is released on a falling edge.
module tb_pll_reset_sequencer;

    logic       clk;
    logic       reset_n;
    logic       pll_locked;
    logic       restart;
    logic       pll_rst;
    logic [2:0] domain_reset;
    logic       ready;
    logic [3:0] lock_loss_cnt;
    logic [3:0] retry_cnt;

    int n_checks;
    int n_fail;

    pll_reset_sequencer #(
        .N_DOMAINS      (3),
        .PLL_RST_CYCLES (4),
        .LOCK_TIMEOUT   (32),
        .LOCK_STABLE    (8),
        .STAGGER        (2),
        .CNT_WIDTH      (4)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .pll_locked    (pll_locked),
        .restart       (restart),
        .pll_rst       (pll_rst),
        .domain_reset  (domain_reset),
        .ready         (ready),
        .lock_loss_cnt (lock_loss_cnt),
        .retry_cnt     (retry_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hold reset across a couple of edges, then release it on a falling edge (cycle 0).
    task do_reset();
        reset_n    = 1'b0;
        pll_locked = 1'b0;
        restart    = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task test_reset();
        reset_n    = 1'b0;
        pll_locked = 1'b0;
        restart    = 1'b0;
        repeat (2) @(negedge clk);
        n_checks += 5;
        if (pll_rst !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_pll_rst got=%b exp=1", pll_rst); end
        if (domain_reset !== 3'b111) begin n_fail++; $display("[TB] FAIL reset_domain got=%b exp=111", domain_reset); end
        if (ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ready got=%b exp=0", ready); end
        if (lock_loss_cnt !== 4'd0) begin n_fail++; $display("[TB] FAIL reset_loss_cnt got=%0d exp=0", lock_loss_cnt); end
        if (retry_cnt !== 4'd0) begin n_fail++; $display("[TB] FAIL reset_retry_cnt got=%0d exp=0", retry_cnt); end
    endtask

    // Lock raised after edge 10: lk seen at 13, RELEASE at 20, 100 at 22, 000 at 24, RUN at 26.
    task test_bringup();
        logic [2:0] exp_dr;
        logic       exp_rst;
        logic       exp_ready;
        do_reset();
        for (int cyc = 0; cyc <= 30; cyc++) begin
            if (cyc > 0) @(negedge clk);
            exp_rst   = (cyc < 4);
            exp_dr    = (cyc < 20) ? 3'b111 : (cyc < 22) ? 3'b110 : (cyc < 24) ? 3'b100 : 3'b000;
            exp_ready = (cyc >= 26);
            n_checks += 3;
            if (pll_rst !== exp_rst) begin n_fail++; $display("[TB] FAIL bringup_pll_rst cyc=%0d got=%b exp=%b", cyc, pll_rst, exp_rst); end
            if (domain_reset !== exp_dr) begin n_fail++; $display("[TB] FAIL bringup_domain cyc=%0d got=%b exp=%b", cyc, domain_reset, exp_dr); end
            if (ready !== exp_ready) begin n_fail++; $display("[TB] FAIL bringup_ready cyc=%0d got=%b exp=%b", cyc, ready, exp_ready); end
            if (cyc == 10) pll_locked = 1'b1;
        end
        n_checks += 2;
        if (lock_loss_cnt !== 4'd0) begin n_fail++; $display("[TB] FAIL bringup_loss_cnt got=%0d exp=0", lock_loss_cnt); end
        if (retry_cnt !== 4'd0) begin n_fail++; $display("[TB] FAIL bringup_retry_cnt got=%0d exp=0", retry_cnt); end
    endtask

    // Restart from RUN with lock held: PLL_RST 4 cycles, lk already high, RUN 18 edges later.
    task test_restart_run();
        logic exp_rst;
        logic exp_ready;
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        n_checks += 4;
        if (domain_reset !== 3'b111) begin n_fail++; $display("[TB] FAIL restart_domain got=%b exp=111", domain_reset); end
        if (ready !== 1'b0) begin n_fail++; $display("[TB] FAIL restart_ready got=%b exp=0", ready); end
        if (pll_rst !== 1'b1) begin n_fail++; $display("[TB] FAIL restart_pll_rst got=%b exp=1", pll_rst); end
        if (lock_loss_cnt !== 4'd0) begin n_fail++; $display("[TB] FAIL restart_loss_cnt got=%0d exp=0", lock_loss_cnt); end
        for (int i = 1; i <= 18; i++) begin
            @(negedge clk);
            exp_rst   = (i < 4);
            exp_ready = (i >= 18);
            n_checks += 2;
            if (pll_rst !== exp_rst) begin n_fail++; $display("[TB] FAIL restart_rerun_pll_rst i=%0d got=%b exp=%b", i, pll_rst, exp_rst); end
            if (ready !== exp_ready) begin n_fail++; $display("[TB] FAIL restart_rerun_ready i=%0d got=%b exp=%b", i, ready, exp_ready); end
        end
        n_checks += 1;
        if (domain_reset !== 3'b000) begin n_fail++; $display("[TB] FAIL restart_rerun_domain got=%b exp=000", domain_reset); end
    endtask

    // Lock dropped while domain_reset=100; the synchroniser delays the abort to 3 edges later.
    task test_lock_loss_release();
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        for (int i = 1; i <= 14; i++) @(negedge clk);
        n_checks += 1;
        if (domain_reset !== 3'b100) begin n_fail++; $display("[TB] FAIL loss_pre_domain got=%b exp=100", domain_reset); end
        pll_locked = 1'b0;
        repeat (2) @(negedge clk);
        n_checks += 1;
        if (domain_reset !== 3'b000) begin n_fail++; $display("[TB] FAIL loss_lag_domain got=%b exp=000", domain_reset); end
        @(negedge clk);
        n_checks += 4;
        if (domain_reset !== 3'b111) begin n_fail++; $display("[TB] FAIL loss_domain got=%b exp=111", domain_reset); end
        if (pll_rst !== 1'b1) begin n_fail++; $display("[TB] FAIL loss_pll_rst got=%b exp=1", pll_rst); end
        if (ready !== 1'b0) begin n_fail++; $display("[TB] FAIL loss_ready got=%b exp=0", ready); end
        if (lock_loss_cnt !== 4'd1) begin n_fail++; $display("[TB] FAIL loss_cnt got=%0d exp=1", lock_loss_cnt); end
        pll_locked = 1'b1;
        for (int j = 1; j <= 18; j++) begin
            @(negedge clk);
            if (j >= 17) begin
                n_checks += 1;
                if (ready !== (j == 18)) begin n_fail++; $display("[TB] FAIL loss_rerun_ready j=%0d got=%b exp=%b", j, ready, (j == 18)); end
            end
        end
        n_checks += 1;
        if (lock_loss_cnt !== 4'd1) begin n_fail++; $display("[TB] FAIL loss_cnt_after got=%0d exp=1", lock_loss_cnt); end
    endtask

    task test_async_reset();
        n_checks += 2;
        if (ready !== 1'b1) begin n_fail++; $display("[TB] FAIL async_pre_ready got=%b exp=1", ready); end
        if (lock_loss_cnt !== 4'd1) begin n_fail++; $display("[TB] FAIL async_pre_loss_cnt got=%0d exp=1", lock_loss_cnt); end
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        n_checks += 5;
        if (pll_rst !== 1'b1) begin n_fail++; $display("[TB] FAIL async_pll_rst got=%b exp=1", pll_rst); end
        if (domain_reset !== 3'b111) begin n_fail++; $display("[TB] FAIL async_domain got=%b exp=111", domain_reset); end
        if (ready !== 1'b0) begin n_fail++; $display("[TB] FAIL async_ready got=%b exp=0", ready); end
        if (lock_loss_cnt !== 4'd0) begin n_fail++; $display("[TB] FAIL async_loss_cnt got=%0d exp=0", lock_loss_cnt); end
        if (retry_cnt !== 4'd0) begin n_fail++; $display("[TB] FAIL async_retry_cnt got=%0d exp=0", retry_cnt); end
    endtask

    // Lock high 5 samples, low 1, high again: STABLE restarts at 13 so RELEASE lands at 20, not 14.
    task test_stable_glitch();
        logic [2:0] exp_dr;
        do_reset();
        for (int cyc = 0; cyc <= 21; cyc++) begin
            if (cyc > 0) @(negedge clk);
            exp_dr = (cyc < 20) ? 3'b111 : 3'b110;
            n_checks += 1;
            if (domain_reset !== exp_dr) begin n_fail++; $display("[TB] FAIL glitch_domain cyc=%0d got=%b exp=%b", cyc, domain_reset, exp_dr); end
            if (cyc == 4) pll_locked = 1'b1;
            if (cyc == 9) pll_locked = 1'b0;
            if (cyc == 10) pll_locked = 1'b1;
        end
        n_checks += 1;
        if (lock_loss_cnt !== 4'd0) begin n_fail++; $display("[TB] FAIL glitch_loss_cnt got=%0d exp=0", lock_loss_cnt); end
    endtask

    // No lock ever: 4 cycles of pll_rst every 36, retry_cnt steps at each period and sticks at 15.
    task test_timeout_retry();
        logic       exp_rst;
        int         r;
        do_reset();
        for (int cyc = 0; cyc <= 36 * 17 + 5; cyc++) begin
            if (cyc > 0) @(negedge clk);
            exp_rst = ((cyc % 36) < 4);
            r = cyc / 36;
            if (r > 15) r = 15;
            n_checks += 3;
            if (pll_rst !== exp_rst) begin n_fail++; $display("[TB] FAIL retry_pll_rst cyc=%0d got=%b exp=%b", cyc, pll_rst, exp_rst); end
            if (retry_cnt !== 4'(r)) begin n_fail++; $display("[TB] FAIL retry_cnt cyc=%0d got=%0d exp=%0d", cyc, retry_cnt, r); end
            if (ready !== 1'b0) begin n_fail++; $display("[TB] FAIL retry_ready cyc=%0d got=%b exp=0", cyc, ready); end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_bringup();
        test_restart_run();
        test_lock_loss_release();
        test_async_reset();
        test_stable_glitch();
        test_timeout_retry();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
